spi_slave_fifo: RTL and testbench
=================================

// Module: spi_slave_fifo
// PURPOSE
//  Parametrised SPI slave: configurable word width, SPI mode (CPOL/CPHA) and bit order.
//  RX words go into a FIFO with valid/ready pop; TX words come from a holding register with valid/ready load.
//  All SPI pins are oversampled in the clk domain. Sits between the external SPI master and on-chip register/DMA logic.
// PARAMETERS
//  DATA_W      8  word width in bits, >=2
//  CPOL        0  sck idle level
//  CPHA        0  0: sample on leading edge; 1: sample on trailing edge
//  MSB_FIRST   1  1: MSB shifted first; 0: LSB first
//  RX_DEPTH    4  RX FIFO entries, power of 2, >=2
//  SYNC_STAGES 2  flops per pin synchroniser (ss, sck, mosi), >=2
// PORTS
//  clk                    in   1  system clock; must be >= 4x sck frequency
//  data_ready_clr_counter in   1  reset, asynchronous, active-high
//  ss                     in   1  slave select, active-low
//  sck                    in   1  SPI clock from master
//  mosi                   in   1  serial data in
//  miso                   out  1  serial data out; registered, driven even when ss high
//  tx_data                in   DATA_W  next word to transmit
//  tx_valid               in   1  tx_data valid
//  tx_ready               out  1  holding register empty; load on tx_valid&&tx_ready
//  rx_data                out  DATA_W  FIFO head word
//  rx_valid               out  1  FIFO not empty
//  rx_ready               in   1  pop head on rx_valid&&rx_ready
//  rx_level               out  $clog2(RX_DEPTH+1)  FIFO occupancy
//  rx_overflow            out  1  sticky; word dropped because FIFO full
//  ovf_clr                in   1  synchronous clear of rx_overflow
//  done                   out  1  one-clk pulse per completed word
//  busy                   out  1  synchronised ss is low
// BEHAVIOUR
//  Reset: miso=1, tx_ready=1, rx_valid=0, rx_data=0, rx_level=0, rx_overflow=0, done=0, busy=0.
//   Bit counter=0, shift reg=all-ones, FIFO pointers=0.
//  Edges: leading = rising if CPOL=0, else falling. Sample edge = leading if CPHA=0, else trailing.
//   Shift edge = the other edge. Edges are detected on the synchronised sck.
//  Idle (ss_s high): bit counter held at 0, partial word discarded, no done.
//   Shift reg loads holding reg if full (holding then empty, tx_ready=1), else all-ones.
//   miso = first bit of shift reg (MSB or LSB per MSB_FIRST), so CPHA=0 data is valid at ss fall.
//  Active (ss_s low):
//   - Sample edge: capture mosi_s into the RX shifter and increment the bit counter.
//   - Shift edge: advance the TX shifter and update miso. For CPHA=1, the first shift edge presents bit 0.
//  Word complete (DATA_W-th sample edge):
//   - done=1 for 1 clk, SYNC_STAGES+1 clks after the sck pin edge.
//   - Bit counter wraps to 0. TX shifter reloads from holding reg if full, else all-ones (underrun sends 1s).
//   - Push the word to the FIFO in the done cycle; rx_valid/rx_level update on the next clk.
//  FIFO:
//   - Push when full drops the word and sets rx_overflow. Exception: a pop in the same clk frees the slot and the push is accepted.
//   - Pop when empty is ignored. rx_data is the head word, registered, and stable while rx_valid && !rx_ready.
//   - rx_overflow clears on ovf_clr. A set in the same clk as ovf_clr wins.
//  tx handshake: tx_ready=0 while the holding reg is full.
//   A load in the same clk as the reload from the holding reg is accepted (new word held).
//  ss deasserted mid-word: partial RX bits discarded, no push, no done; TX word in progress is lost.
//  Reset asserted mid-transfer: everything returns to reset values immediately. Transfer resumes at the next ss fall.
//  Pointer/level arithmetic wraps modulo RX_DEPTH; rx_level never exceeds RX_DEPTH.
// TESTING
//  T1 mode0, DATA_W=8: preload tx 0xA5; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1;
//     rx_data=0x3C; 1 done pulse; tx_ready=1 after ss fall.
//  T2 each CPOL/CPHA 0..3, MSB_FIRST=0, DATA_W=12: master sends 0xABC with tx 0x123 -> rx 0xABC; master receives 0x123.
//  T3 RX_DEPTH=4, rx_ready=0, 5 words 0x01..0x05 -> rx_level=4, rx_overflow=1, FIFO pops 0x01..0x04;
//     ovf_clr -> rx_overflow=0.
//  T4 no tx_valid, 2-word burst -> miso all ones both words; simultaneous full push+pop -> word accepted, no overflow.
//  T5 ss raised after 5 bits, then full word 0x81 -> single rx 0x81, exactly 1 done.
//     Reset pulse mid-word -> all outputs at reset values.

Source files
------------

// File: rtl/spi_slave_fifo_if.sv
// Host-side bundle of the SPI slave: TX load handshake,
// RX FIFO pop handshake and status flags.
interface spi_slave_fifo_if #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4
);
  localparam int LW = $clog2(RX_DEPTH + 1);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [LW-1:0]     rx_level;
  logic              rx_overflow;
  logic              ovf_clr;
  logic              done;
  logic              busy;

  modport master (
    output tx_data, tx_valid, rx_ready, ovf_clr,
    input  tx_ready, rx_data, rx_valid, rx_level,
    input  rx_overflow, done, busy
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, ovf_clr,
    output tx_ready, rx_data, rx_valid, rx_level,
    output rx_overflow, done, busy
  );
endinterface

// File: rtl/spi_slave_fifo.sv
// Oversampled SPI slave with RX FIFO and TX holding register.
// All SPI pins pass through SYNC_STAGES-deep synchronisers.
module spi_slave_fifo #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic data_ready_clr_counter,
  input  logic ss,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  spi_slave_fifo_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam int PW = $clog2(RX_DEPTH);
  localparam int LW = $clog2(RX_DEPTH + 1);
  localparam bit MSB = (MSB_FIRST != 0);
  localparam bit SCK_IDLE = (CPOL != 0);

  logic [SYNC_STAGES-1:0] ss_q, sck_q, mosi_q;
  logic ss_s, sck_s, mosi_s, sck_d;
  logic active, rise, fall, lead, trail, smp, sft;

  logic [CW-1:0]     cnt;
  logic              last, word_end;
  logic [DATA_W-1:0] rx_sh, rx_next, word_q;
  logic              done_q;

  logic [DATA_W-1:0] hold, tx_sh, tx_sh_n, tx_shift;
  logic              hold_full, tx_fresh, fresh_n;
  logic              miso_q, miso_n;
  logic              tx_take, tx_load;

  logic [DATA_W-1:0] mem [RX_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_n;
  logic [LW-1:0]     count;
  logic [DATA_W-1:0] head_q, head_n;
  logic              full, pop, push_ok, ovf_set, ovf_q;

  function automatic logic first_bit(input logic [DATA_W-1:0] x);
    return MSB ? x[DATA_W-1] : x[0];
  endfunction

  always_ff @(posedge clk or posedge data_ready_clr_counter) begin
    if (data_ready_clr_counter) begin
      ss_q   <= '1;
      sck_q  <= {SYNC_STAGES{SCK_IDLE}};
      mosi_q <= '0;
      sck_d  <= SCK_IDLE;
    end else begin
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_s;
    end
  end

  assign ss_s   = ss_q[SYNC_STAGES-1];
  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign active = !ss_s;
  assign rise   = sck_s && !sck_d;
  assign fall   = !sck_s && sck_d;
  assign lead   = SCK_IDLE ? fall : rise;
  assign trail  = SCK_IDLE ? rise : fall;
  assign smp    = active && ((CPHA != 0) ? trail : lead);
  assign sft    = active && ((CPHA != 0) ? lead : trail);

  assign last     = (cnt == CW'(DATA_W - 1));
  assign word_end = smp && last;
  assign rx_next  = MSB ? {rx_sh[DATA_W-2:0], mosi_s}
                        : {mosi_s, rx_sh[DATA_W-1:1]};

  always_ff @(posedge clk or posedge data_ready_clr_counter) begin
    if (data_ready_clr_counter) begin
      cnt    <= '0;
      rx_sh  <= '0;
      word_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= word_end;
      if (!active) begin
        cnt <= '0;
      end else if (smp) begin
        cnt   <= last ? '0 : cnt + 1'b1;
        rx_sh <= rx_next;
      end
      if (word_end) word_q <= rx_next;
    end
  end

  // tx_fresh marks a shifter word nobody has clocked out yet,
  // so idle cycles keep it instead of overwriting it.
  assign tx_take  = hold_full && ((!active && !tx_fresh) || word_end);
  assign tx_load  = bus.tx_valid && bus.tx_ready;
  assign tx_shift = MSB ? {tx_sh[DATA_W-2:0], 1'b1}
                        : {1'b1, tx_sh[DATA_W-1:1]};

  always_comb begin
    tx_sh_n = tx_sh;
    fresh_n = tx_fresh;
    miso_n  = miso_q;
    if (!active) begin
      if (!tx_fresh) begin
        tx_sh_n = hold_full ? hold : '1;
        fresh_n = hold_full;
      end
      miso_n = first_bit(tx_sh_n);
    end else if (word_end) begin
      tx_sh_n = hold_full ? hold : '1;
      fresh_n = hold_full;
    end else begin
      if (smp) fresh_n = 1'b0;
      if (sft) begin
        if (cnt != '0) tx_sh_n = tx_shift;
        miso_n = first_bit(tx_sh_n);
      end
    end
  end

  always_ff @(posedge clk or posedge data_ready_clr_counter) begin
    if (data_ready_clr_counter) begin
      hold      <= '0;
      hold_full <= 1'b0;
      tx_sh     <= '1;
      tx_fresh  <= 1'b0;
      miso_q    <= 1'b1;
    end else begin
      tx_sh    <= tx_sh_n;
      tx_fresh <= fresh_n;
      miso_q   <= miso_n;
      if (tx_load) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (tx_take) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign full    = (count == LW'(RX_DEPTH));
  assign pop     = bus.rx_valid && bus.rx_ready;
  assign push_ok = done_q && (!full || pop);
  assign ovf_set = done_q && full && !pop;
  assign rd_n    = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign head_n  = (push_ok && wr_ptr == rd_n) ? word_q : mem[rd_n];

  always_ff @(posedge clk or posedge data_ready_clr_counter) begin
    if (data_ready_clr_counter) begin
      for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= word_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_n;
      head_q <= head_n;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign miso            = miso_q;
  assign bus.tx_ready    = !hold_full || tx_take;
  assign bus.rx_data     = head_q;
  assign bus.rx_valid    = (count != '0);
  assign bus.rx_level    = count;
  assign bus.rx_overflow = ovf_q;
  assign bus.done        = done_q;
  assign bus.busy        = active;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench: one mode-0 8-bit slave plus four 12-bit
// LSB-first slaves, one per SPI mode.
module tb_spi_slave_fifo;
  localparam time H = 80ns;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5ns clk = ~clk;

  logic [4:0] ss_a   = 5'b11111;
  logic [4:0] sck_a  = 5'b01100;
  logic [4:0] mosi_a = 5'b00000;
  wire  [4:0] miso_a;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  spi_slave_fifo_if #(.DATA_W(8), .RX_DEPTH(4)) bus ();

  spi_slave_fifo dut (
    .clk                    (clk),
    .data_ready_clr_counter (rst),
    .ss                     (ss_a[4]),
    .sck                    (sck_a[4]),
    .mosi                   (mosi_a[4]),
    .miso                   (miso_a[4]),
    .bus                    (bus.slave)
  );

  logic [11:0] t2_tx = 12'h123;
  logic [3:0]  t2_txv = 4'b0000;
  wire  [11:0] t2_rx [4];
  wire  [3:0]  t2_rxv;

  for (genvar g = 0; g < 4; g++) begin : gm
    spi_slave_fifo_if #(.DATA_W(12), .RX_DEPTH(4)) b ();
    assign b.tx_data  = t2_tx;
    assign b.tx_valid = t2_txv[g];
    assign b.rx_ready = 1'b0;
    assign b.ovf_clr  = 1'b0;
    assign t2_rx[g]   = b.rx_data;
    assign t2_rxv[g]  = b.rx_valid;
    spi_slave_fifo #(
      .DATA_W(12), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(0)
    ) u (
      .clk                    (clk),
      .data_ready_clr_counter (rst),
      .ss                     (ss_a[g]),
      .sck                    (sck_a[g]),
      .mosi                   (mosi_a[g]),
      .miso                   (miso_a[g]),
      .bus                    (b.slave)
    );
  end

  always @(posedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int m, input int n, input bit cpol,
                      input bit cpha, input bit msb,
                      input logic [31:0] mo, output logic [31:0] mi);
    int b;
    mi = '0;
    @(negedge clk);
    sck_a[m] = cpol;
    ss_a[m]  = 1'b0;
    b = msb ? n - 1 : 0;
    if (!cpha) mosi_a[m] = mo[b];
    #H;
    for (int i = 0; i < n; i++) begin
      b = msb ? n - 1 - i : i;
      if (cpha) begin
        sck_a[m]  = ~cpol;
        mosi_a[m] = mo[b];
        #H;
        mi[b]    = miso_a[m];
        sck_a[m] = cpol;
        #H;
      end else begin
        mi[b]    = miso_a[m];
        sck_a[m] = ~cpol;
        #H;
        sck_a[m] = cpol;
        if (i + 1 < n) mosi_a[m] = mo[msb ? n - 2 - i : i + 1];
        #H;
      end
    end
    ss_a[m] = 1'b1;
    #H;
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    @(negedge clk);
    chk(nm, bus.rx_data, exp);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"},  miso_a[4], 1);
    chk({tag, "_txrdy"}, bus.tx_ready, 1);
    chk({tag, "_rxv"},   bus.rx_valid, 0);
    chk({tag, "_rxd"},   bus.rx_data, 0);
    chk({tag, "_lvl"},   bus.rx_level, 0);
    chk({tag, "_ovf"},   bus.rx_overflow, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_busy"},  bus.busy, 0);
  endtask

  typedef struct {
    logic       txv;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [5];
    logic [31:0] mi;
    int d0;
    bit seen;

    vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};
    vt[1] = '{1'b1, 8'h5A, 8'hC3, 8'h5A};
    vt[2] = '{1'b0, 8'h00, 8'hFF, 8'hFF};
    vt[3] = '{1'b1, 8'h00, 8'h00, 8'h00};
    vt[4] = '{1'b1, 8'h96, 8'h7E, 8'h96};

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      t2_txv[m] = 1'b1;
      @(negedge clk);
      t2_txv[m] = 1'b0;
      repeat (3) @(negedge clk);
      xfer(m, 12, 1'(m / 2), 1'(m % 2), 1'b0, 32'hABC, mi);
      chk($sformatf("t2_miso_m%0d", m), mi[11:0], 12'h123);
      chk($sformatf("t2_rx_m%0d", m), t2_rx[m], 12'hABC);
      chk($sformatf("t2_rxv_m%0d", m), t2_rxv[m], 1);
    end

    for (int i = 0; i < 5; i++) begin
      if (vt[i].txv) load_tx(vt[i].tx);
      chk($sformatf("v%0d_txrdy", i), bus.tx_ready, 1);
      d0 = done_cnt;
      xfer(4, 8, 1'b0, 1'b0, 1'b1, {24'h0, vt[i].mo}, mi);
      chk($sformatf("v%0d_miso", i), mi[7:0], vt[i].exp_mi);
      chk($sformatf("v%0d_done", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_rxv", i), bus.rx_valid, 1);
      pop_chk($sformatf("v%0d_rxd", i), vt[i].mo);
      chk($sformatf("v%0d_empty", i), bus.rx_valid, 0);
    end

    for (int k = 1; k <= 5; k++)
      xfer(4, 8, 1'b0, 1'b0, 1'b1, k, mi);
    chk("ovf_lvl", bus.rx_level, 4);
    chk("ovf_flag", bus.rx_overflow, 1);
    for (int k = 1; k <= 4; k++)
      pop_chk($sformatf("ovf_pop%0d", k), 8'(k));
    chk("ovf_drained", bus.rx_valid, 0);
    chk("ovf_sticky", bus.rx_overflow, 1);
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", bus.rx_overflow, 0);

    d0 = done_cnt;
    xfer(4, 16, 1'b0, 1'b0, 1'b1, 32'h1122, mi);
    chk("burst_miso", mi[15:0], 16'hFFFF);
    chk("burst_done", done_cnt - d0, 2);
    xfer(4, 16, 1'b0, 1'b0, 1'b1, 32'h3344, mi);
    chk("burst_lvl", bus.rx_level, 4);
    seen = 1'b0;
    fork
      xfer(4, 8, 1'b0, 1'b0, 1'b1, 32'h55, mi);
      begin
        for (int c = 0; c < 400 && !seen; c++) begin
          @(negedge clk);
          seen = bus.done;
        end
        chk("pp_done_seen", seen, 1);
        if (seen) begin
          chk("pp_head", bus.rx_data, 8'h11);
          bus.rx_ready = 1'b1;
          @(negedge clk);
          bus.rx_ready = 1'b0;
        end
      end
    join
    chk("pp_ovf", bus.rx_overflow, 0);
    chk("pp_lvl", bus.rx_level, 4);
    pop_chk("pp_pop1", 8'h22);
    pop_chk("pp_pop2", 8'h33);
    pop_chk("pp_pop3", 8'h44);
    pop_chk("pp_pop4", 8'h55);

    d0 = done_cnt;
    xfer(4, 5, 1'b0, 1'b0, 1'b1, 32'h15, mi);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_rxv", bus.rx_valid, 0);
    xfer(4, 8, 1'b0, 1'b0, 1'b1, 32'h81, mi);
    chk("abort_next_done", done_cnt - d0, 1);
    chk("abort_next_lvl", bus.rx_level, 1);
    chk("abort_next_rxd", bus.rx_data, 8'h81);

    load_tx(8'h5A);
    load_tx(8'h6B);
    chk("hold_full", bus.tx_ready, 0);
    @(negedge clk);
    ss_a[4]   = 1'b0;
    mosi_a[4] = 1'b1;
    #H;
    repeat (3) begin
      sck_a[4] = 1'b1;
      #H;
      sck_a[4] = 1'b0;
      #H;
    end
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("midrst");
    ss_a[4] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    xfer(4, 8, 1'b0, 1'b0, 1'b1, 32'hC3, mi);
    chk("post_miso", mi[7:0], 8'hFF);
    chk("post_done", done_cnt - d0, 1);
    chk("post_rxd", bus.rx_data, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
